// File: rtl/alarm_countdown_ctrl_if.sv
// Switch/button inputs and display/lamp outputs of the alarm countdown controller.
// master drives the board inputs; slave is the controller itself.
interface alarm_countdown_ctrl_if;
    logic [9:0] switches;
    logic       pause_start_stop_btn;
    logic [8:0] time_remaining;
    logic [9:0] leds;
    logic       buzzer;
    logic       running;

    modport master (
        output switches,
        output pause_start_stop_btn,
        input  time_remaining,
        input  leds,
        input  buzzer,
        input  running
    );

    modport slave (
        input  switches,
        input  pause_start_stop_btn,
        output time_remaining,
        output leds,
        output buzzer,
        output running
    );
endinterface

// File: rtl/alarm_countdown_ctrl.sv
// Alarm-clock countdown sequencer: loads a start time, counts it down once per second, sounds alarm.
// Optional ALARM_TIMEOUT_EN: alarm clears itself after ALARM_SECS seconds.
module alarm_countdown_ctrl #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned ALARM_SECS = 10
) (
    input logic                   clk,
    input logic                   reset,
    alarm_countdown_ctrl_if.slave bus
);

    localparam int unsigned DivW = $clog2(TICK_DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRunning, StPaused, StAlarm} state_e;

    state_e          state_q, state_d;
    logic [8:0]      tr_q, tr_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]      leds_q, leds_d;
    logic            buzzer_q, running_q;

    logic       btn_meta_q, btn_sync_q, btn_prev_q;
    logic [1:0] fill_q;
    logic       press_q;
    logic       load;
    logic       div_active;
    logic       tick;
    logic       timeout;
    logic       unused_sw;

    assign unused_sw = bus.switches[9];

    // Edge detect is held off until the synchronizer holds real samples, so a button
    // held low across reset never looks like a fresh press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_q <= 1'b1;
            btn_sync_q <= 1'b1;
            btn_prev_q <= 1'b1;
            fill_q     <= 2'd0;
            press_q    <= 1'b0;
        end else begin
            btn_meta_q <= bus.pause_start_stop_btn;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
            press_q <= (fill_q == 2'd3) && btn_prev_q && !btn_sync_q;
        end
    end

`ifdef ALARM_TIMEOUT_EN
    localparam int unsigned SecsW = $clog2(ALARM_SECS + 1);

    logic [SecsW-1:0] secs_q, secs_d;

    assign div_active = (state_q == StRunning) || (state_q == StAlarm);
    assign timeout    = (state_q == StAlarm) && tick && (secs_q == SecsW'(ALARM_SECS - 1));

    always_comb begin
        secs_d = secs_q;
        if (state_q != StAlarm) begin
            secs_d = '0;
        end else if (tick) begin
            secs_d = secs_q + SecsW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            secs_q <= '0;
        end else begin
            secs_q <= secs_d;
        end
    end
`else
    localparam int unsigned unused_alarm_secs = ALARM_SECS;

    assign div_active = (state_q == StRunning);
    assign timeout    = 1'b0;
`endif

    assign tick = div_active && (div_cnt_q == DivMax);

    // Divider holds its count while paused so the partial second survives.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (load) begin
            div_cnt_d = '0;
        end else if (div_active) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        tr_d    = tr_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                tr_d = bus.switches[8:0];
                if (press_q && (bus.switches[8:0] != 9'd0)) begin
                    state_d = StRunning;
                    load    = 1'b1;
                end
            end
            StRunning: begin
                if (tick) begin
                    tr_d = tr_q - 9'd1;
                end
                // Reaching zero beats a coincident pause request.
                if (tick && (tr_q == 9'd1)) begin
                    state_d = StAlarm;
                end else if (press_q) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (press_q) begin
                    state_d = StRunning;
                end
            end
            StAlarm: begin
                tr_d = 9'd0;
                if (press_q || timeout) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        leds_d = 10'd0;
        unique case (state_d)
            StRunning: leds_d = 10'd1;
            StPaused:  leds_d = 10'd2;
            StAlarm:   leds_d = '1;
            default:   leds_d = 10'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            tr_q      <= 9'd0;
            div_cnt_q <= '0;
            leds_q    <= 10'd0;
            buzzer_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tr_q      <= tr_d;
            div_cnt_q <= div_cnt_d;
            leds_q    <= leds_d;
            buzzer_q  <= (state_d == StAlarm);
            running_q <= (state_d == StRunning);
        end
    end

    assign bus.time_remaining = tr_q;
    assign bus.leds           = leds_q;
    assign bus.buzzer         = buzzer_q;
    assign bus.running        = running_q;

endmodule

// File: tb/tb_alarm_countdown_ctrl.sv
// Bench for alarm_countdown_ctrl: directed scenarios plus random button/switch traffic
// checked every cycle against a behavioural model of the countdown rules.
module tb_alarm_countdown_ctrl;

    localparam int unsigned TickDiv   = 10;
    localparam int unsigned AlarmSecs = 2;
    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MPause = 2;
    localparam int MAlarm = 3;
`ifdef ALARM_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    alarm_countdown_ctrl_if bus ();

    alarm_countdown_ctrl #(
        .TICK_DIV  (TickDiv),
        .ALARM_SECS(AlarmSecs)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        int         mode;
        int         tr;
        int         phase;
        int         secs;
        logic [4:0] hist;
        int         seen;
    } mstate_t;

    mstate_t m;

    // One clock edge of the countdown rules; a press is a 1->0 button change seen
    // three edges earlier, once five post-reset samples exist.
    function automatic mstate_t model_next(mstate_t s, int sw, logic btn);
        mstate_t n;
        bit pr;
        bit counting;
        bit tick;
        n        = s;
        n.hist   = {s.hist[3:0], btn};
        n.seen   = (s.seen < 5) ? s.seen + 1 : 5;
        pr       = (n.seen == 5) && n.hist[4] && !n.hist[3];
        counting = (s.mode == MRun) || (TimeoutEn && s.mode == MAlarm);
        tick     = counting && (s.phase == int'(TickDiv) - 1);
        if (tick) n.phase = 0;
        else if (counting) n.phase = s.phase + 1;
        case (s.mode)
            MIdle: begin
                n.tr = sw;
                if (pr && sw != 0) begin
                    n.mode  = MRun;
                    n.phase = 0;
                end
            end
            MRun: begin
                if (tick) n.tr = s.tr - 1;
                if (tick && s.tr == 1) begin
                    n.mode = MAlarm;
                    n.secs = 0;
                end else if (pr) begin
                    n.mode = MPause;
                end
            end
            MPause: begin
                if (pr) n.mode = MRun;
            end
            default: begin
                n.tr = 0;
                if (tick) n.secs = s.secs + 1;
                if (pr || (TimeoutEn && n.secs == int'(AlarmSecs))) n.mode = MIdle;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else m <= model_next(m, int'(bus.switches[8:0]), bus.pause_start_stop_btn);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        bus.pause_start_stop_btn = 1'b1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.switches = 10'd0;
        bus.pause_start_stop_btn = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.time_remaining, bus.leds, bus.buzzer, bus.running} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bus.time_remaining, bus.leds, bus.buzzer, bus.running});
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.leds, bus.buzzer, bus.running} !== 12'd0) begin
            bad++;
            $display("FAIL idle_after_reset got=%h exp=0", {bus.leds, bus.buzzer, bus.running});
        end
        bus.switches = 10'd5;
        @(negedge clk);
        total++;
        if (bus.time_remaining !== 9'd5) begin
            bad++;
            $display("FAIL idle_tracks_switches got=%0d exp=5", bus.time_remaining);
        end
    endtask

    task automatic test_countdown();
        int lat;
        bus.switches = 10'd3;
        @(negedge clk);
        bus.pause_start_stop_btn = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 4) bus.pause_start_stop_btn = 1'b1;
            if (bus.running === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.pause_start_stop_btn = 1'b1;
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL start_latency got=%0d exp=4", lat);
        end
        total++;
        if (bus.time_remaining !== 9'd3 || bus.leds !== 10'd1) begin
            bad++;
            $display("FAIL running_entry got tr=%0d leds=%h exp tr=3 leds=001",
                     bus.time_remaining, bus.leds);
        end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 9 || i == 10 || i == 20 || i == 29) begin
                total++;
                if (bus.time_remaining !== ((i == 9) ? 9'd3 : (i == 29) ? 9'd1 :
                                            (i == 10) ? 9'd2 : 9'd1)) begin
                    bad++;
                    $display("FAIL countdown_step cycle=%0d got=%0d", i, bus.time_remaining);
                end
            end
        end
        total++;
        if ({bus.time_remaining, bus.leds, bus.buzzer, bus.running} !==
            {9'd0, 10'h3ff, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL alarm_entry got tr=%0d leds=%h buz=%b run=%b exp tr=0 leds=3ff buz=1 run=0",
                     bus.time_remaining, bus.leds, bus.buzzer, bus.running);
        end
    endtask

    task automatic test_alarm_exit();
        int lat;
        bus.switches = 10'd6;
        bus.pause_start_stop_btn = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 4) bus.pause_start_stop_btn = 1'b1;
            if (bus.buzzer === 1'b0) begin
                lat = i;
                break;
            end
        end
        bus.pause_start_stop_btn = 1'b1;
        total++;
        if (lat != 4 || bus.leds !== 10'd0 || bus.running !== 1'b0) begin
            bad++;
            $display("FAIL alarm_exit got lat=%0d leds=%h run=%b exp lat=4 leds=000 run=0",
                     lat, bus.leds, bus.running);
        end
        @(negedge clk);
        total++;
        if (bus.time_remaining !== 9'd6) begin
            bad++;
            $display("FAIL alarm_exit_tracks got=%0d exp=6", bus.time_remaining);
        end
        bus.switches = 10'd11;
        @(negedge clk);
        total++;
        if (bus.time_remaining !== 9'd11) begin
            bad++;
            $display("FAIL idle_tracks_new got=%0d exp=11", bus.time_remaining);
        end
    endtask

    task automatic test_zero_start();
        bus.switches = 10'd0;
        @(negedge clk);
        bus.pause_start_stop_btn = 1'b0;
        repeat (4) @(negedge clk);
        bus.pause_start_stop_btn = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if ({bus.time_remaining, bus.leds, bus.buzzer, bus.running} !== 21'd0) begin
            bad++;
            $display("FAIL zero_start_ignored got tr=%0d leds=%h buz=%b run=%b exp all 0",
                     bus.time_remaining, bus.leds, bus.buzzer, bus.running);
        end
    endtask

    task automatic test_pause();
        int lat;
        int held_bad;
        bus.switches = 10'd4;
        @(negedge clk);
        bus.pause_start_stop_btn = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) bus.pause_start_stop_btn = 1'b1;
            if (bus.running === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.pause_start_stop_btn = 1'b1;
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL pause_start_latency got=%0d exp=4", lat);
        end
        repeat (11) @(negedge clk);
        bus.pause_start_stop_btn = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) bus.pause_start_stop_btn = 1'b1;
            if (bus.leds === 10'd2) begin
                lat = i;
                break;
            end
        end
        bus.pause_start_stop_btn = 1'b1;
        total++;
        if (lat != 4 || bus.time_remaining !== 9'd3 || bus.running !== 1'b0) begin
            bad++;
            $display("FAIL pause_entry got lat=%0d tr=%0d run=%b exp lat=4 tr=3 run=0",
                     lat, bus.time_remaining, bus.running);
        end
        held_bad = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.time_remaining !== 9'd3 || bus.leds !== 10'd2) held_bad++;
        end
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL pause_hold got bad_cycles=%0d exp=0", held_bad);
        end
        bus.pause_start_stop_btn = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) bus.pause_start_stop_btn = 1'b1;
            if (bus.running === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.pause_start_stop_btn = 1'b1;
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL resume_latency got=%0d exp=4", lat);
        end
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.time_remaining === 9'd2) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat != 5) begin
            bad++;
            $display("FAIL partial_second_kept got=%0d exp=5", lat);
        end
        repeat (22) @(negedge clk);
        bus.pause_start_stop_btn = 1'b0;
        repeat (3) @(negedge clk);
        bus.pause_start_stop_btn = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (bus.buzzer !== 1'b0 || bus.running !== 1'b0) begin
            bad++;
            $display("FAIL pause_scenario_end got buz=%b run=%b exp 0 0", bus.buzzer, bus.running);
        end
    endtask

`ifdef ALARM_TIMEOUT_EN
    task automatic test_alarm_timeout();
        int lat;
        bus.switches = 10'd1;
        @(negedge clk);
        bus.pause_start_stop_btn = 1'b0;
        repeat (3) @(negedge clk);
        bus.pause_start_stop_btn = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.buzzer === 1'b1) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat == 0) begin
            bad++;
            $display("FAIL timeout_alarm_reached got buz=%b exp=1", bus.buzzer);
        end
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.buzzer === 1'b0) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat != 20 || bus.leds !== 10'd0) begin
            bad++;
            $display("FAIL alarm_timeout got=%0d leds=%h exp=20 leds=000", lat, bus.leds);
        end
    endtask
`endif

    task automatic test_reset_mid_run();
        int found;
        do_reset();
        bus.switches = 10'd9;
        bus.pause_start_stop_btn = 1'b0;
        repeat (3) @(negedge clk);
        bus.pause_start_stop_btn = 1'b1;
        found = 0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (bus.running === 1'b1 && bus.time_remaining === 9'd7) begin
                found = 1;
                break;
            end
        end
        total++;
        if (found == 0) begin
            bad++;
            $display("FAIL reach_seven got tr=%0d run=%b exp tr=7 run=1",
                     bus.time_remaining, bus.running);
        end
        bus.pause_start_stop_btn = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if ({bus.time_remaining, bus.leds, bus.buzzer, bus.running} !== 21'd0) begin
            bad++;
            $display("FAIL async_reset_clear got tr=%0d leds=%h buz=%b run=%b exp all 0",
                     bus.time_remaining, bus.leds, bus.buzzer, bus.running);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (bus.running !== 1'b0 || bus.leds !== 10'd0 || bus.time_remaining !== 9'd9) begin
            bad++;
            $display("FAIL held_btn_no_press got run=%b leds=%h tr=%0d exp run=0 leds=000 tr=9",
                     bus.running, bus.leds, bus.time_remaining);
        end
        bus.pause_start_stop_btn = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (bus.running !== 1'b0) begin
            bad++;
            $display("FAIL release_no_press got run=%b exp=0", bus.running);
        end
    endtask

    task automatic test_random();
        int hold;
        int r;
        logic [9:0] exp_leds;
        logic [20:0] act;
        logic [20:0] exp;
        do_reset();
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            exp_leds = (m.mode == MRun) ? 10'd1 : (m.mode == MPause) ? 10'd2 :
                       (m.mode == MAlarm) ? 10'h3ff : 10'd0;
            exp = {9'(m.tr), exp_leds, (m.mode == MAlarm), (m.mode == MRun)};
            act = {bus.time_remaining, bus.leds, bus.buzzer, bus.running};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL random cycle=%0d got=%h exp=%h", i, act, exp);
            end
            if (i == 2000) reset = 1'b0;
            if (i == 2003) reset = 1'b1;
            if (hold == 0) begin
                if ($urandom_range(0, 9) < 4) begin
                    bus.pause_start_stop_btn = 1'b0;
                    hold = $urandom_range(1, 6);
                end else begin
                    bus.pause_start_stop_btn = 1'b1;
                    hold = $urandom_range(1, 40);
                end
            end
            hold--;
            if ($urandom_range(0, 29) == 0) begin
                r = $urandom_range(0, 9);
                if (r == 0) bus.switches = 10'($urandom_range(0, 1) << 9);
                else if (r == 9) bus.switches = 10'($urandom_range(0, 40));
                else bus.switches = 10'($urandom_range(1, 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_alarm_exit();
        test_zero_start();
        test_pause();
`ifdef ALARM_TIMEOUT_EN
        test_alarm_timeout();
`endif
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
